// File: rtl/rf_arb_pkg.sv
// Shared types and defaults for the register-file write arbiter.
// Holds the width defaults and the arbiter FSM state enum.
package rf_arb_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_B_DEPTH  = 4;
    localparam int RF_MAX_WAIT = 4;

    typedef enum logic {
        NORMAL  = 1'b0,
        FORCE_B = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rf_arb_fifo.sv
// Port-B write queue for the register-file write arbiter.
// Ports: push_*/pop_i in, full_o/empty_o/head_* out, ent_valid_o/ent_addr_o
// expose every slot for pending-write hazard matching.
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DW    = RF_DATA_W,
    parameter int AW    = RF_ADDR_W,
    parameter int DEPTH = RF_B_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_i,
    input  logic [AW-1:0]             push_addr_i,
    input  logic [DW-1:0]             push_data_i,
    input  logic                      pop_i,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [AW-1:0]             head_addr_o,
    output logic [DW-1:0]             head_data_o,
    output logic [DEPTH-1:0]          ent_valid_o,
    output logic [DEPTH-1:0][AW-1:0]  ent_addr_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0]         vld_q, vld_d;
    logic [DEPTH-1:0][AW-1:0] addr_q;
    logic [DW-1:0]            data_q [DEPTH];
    logic                     do_push;
    logic                     do_pop;

    assign full_o  = &vld_q;
    assign empty_o = ~|vld_q;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Per-slot valid bits make full/empty and hazard lookup trivial;
    // pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PW'(1);
        end
        if (do_push) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage needs no reset: slots are qualified by vld_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_q[wr_ptr_q] <= push_addr_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign ent_valid_o = vld_q;
    assign ent_addr_o  = addr_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates pipeline writeback (A) and queued late returns (B) onto
// the single register-file write port, with starvation guard on B.
// Ports: a_*/b_* valid-ready write inputs, rf_we/rf_wa/rf_wd registered
// write port, chk_addrN/chk_hitN pending-write hazard query.
// Optional: define RF_ARB_STATS_EN to add the stall_cnt output.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_W,
    parameter int ADDR_WIDTH = RF_ADDR_W,
    parameter int B_DEPTH    = RF_B_DEPTH,
    parameter int MAX_WAIT   = RF_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_wa,
    output logic [DATA_WIDTH-1:0] rf_wd,
`ifdef RF_ARB_STATS_EN
    output logic [31:0]           stall_cnt,
`endif
    input  logic [ADDR_WIDTH-1:0] chk_addr1,
    input  logic [ADDR_WIDTH-1:0] chk_addr2,
    output logic                  chk_hit1,
    output logic                  chk_hit2
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    logic                             fifo_full;
    logic                             fifo_empty;
    logic [ADDR_WIDTH-1:0]            head_addr;
    logic [DATA_WIDTH-1:0]            head_data;
    logic [B_DEPTH-1:0]               ent_valid;
    logic [B_DEPTH-1:0][ADDR_WIDTH-1:0] ent_addr;

    arb_state_e            state_q, state_d;
    logic [WW-1:0]         wait_q, wait_d;
    logic                  a_ready_q;
    logic                  rf_we_q;
    logic [ADDR_WIDTH-1:0] rf_wa_q;
    logic [DATA_WIDTH-1:0] rf_wd_q;

    logic b_push;
    logic head_grant;
    logic a_write;

    // Writes to x0 complete the handshake but are dropped here.
    assign b_ready    = ~fifo_full;
    assign b_push     = b_valid & ~fifo_full & (b_addr != '0);
    assign head_grant = ~fifo_empty &
                        ((state_q == FORCE_B) | ~a_valid);
    assign a_write    = a_valid & a_ready_q & (a_addr != '0);

    rf_arb_fifo #(
        .DW    (DATA_WIDTH),
        .AW    (ADDR_WIDTH),
        .DEPTH (B_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (b_push),
        .push_addr_i (b_addr),
        .push_data_i (b_data),
        .pop_i       (head_grant),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .ent_valid_o (ent_valid),
        .ent_addr_o  (ent_addr)
    );

    // wait_d counts bypasses of the current head; FORCE_B is entered
    // the cycle after the MAX_WAIT-th bypass and lasts one grant.
    always_comb begin
        wait_d  = wait_q;
        state_d = state_q;
        if (fifo_empty || head_grant) begin
            wait_d = '0;
        end else if (wait_q != WW'(MAX_WAIT)) begin
            wait_d = wait_q + WW'(1);
        end
        unique case (state_q)
            NORMAL: begin
                if (wait_d == WW'(MAX_WAIT)) state_d = FORCE_B;
            end
            FORCE_B: begin
                if (head_grant || fifo_empty) state_d = NORMAL;
            end
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= NORMAL;
            wait_q    <= '0;
            a_ready_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            a_ready_q <= (state_d == NORMAL);
        end
    end

    // Head grant and A write are mutually exclusive by construction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q <= 1'b0;
            rf_wa_q <= '0;
            rf_wd_q <= '0;
        end else begin
            rf_we_q <= head_grant | a_write;
            if (head_grant) begin
                rf_wa_q <= head_addr;
                rf_wd_q <= head_data;
            end else if (a_write) begin
                rf_wa_q <= a_addr;
                rf_wd_q <= a_data;
            end
        end
    end

    always_comb begin
        chk_hit1 = rf_we_q & (rf_wa_q == chk_addr1);
        chk_hit2 = rf_we_q & (rf_wa_q == chk_addr2);
        for (int i = 0; i < B_DEPTH; i++) begin
            if (ent_valid[i] && ent_addr[i] == chk_addr1) chk_hit1 = 1'b1;
            if (ent_valid[i] && ent_addr[i] == chk_addr2) chk_hit2 = 1'b1;
        end
        if (chk_addr1 == '0) chk_hit1 = 1'b0;
        if (chk_addr2 == '0) chk_hit2 = 1'b0;
    end

    assign a_ready = a_ready_q;
    assign rf_we   = rf_we_q;
    assign rf_wa   = rf_wa_q;
    assign rf_wd   = rf_wd_q;

`ifdef RF_ARB_STATS_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (a_valid && !a_ready_q && stall_q != '1) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: queue-based reference
// model, scoreboard of expected commits, directed and random stimulus.
module tb_rf_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int BD = 4;
    localparam int MW = 4;

    logic          clk;
    logic          rst_n;
    logic          a_valid, a_ready, b_valid, b_ready;
    logic [AW-1:0] a_addr, b_addr, rf_wa, chk_addr1, chk_addr2;
    logic [DW-1:0] a_data, b_data, rf_wd;
    logic          rf_we, chk_hit1, chk_hit2;
`ifdef RF_ARB_STATS_EN
    logic [31:0]   stall_cnt;
`endif

    rf_write_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
`ifdef RF_ARB_STATS_EN
        .stall_cnt (stall_cnt),
`endif
        .chk_addr1 (chk_addr1),
        .chk_addr2 (chk_addr2),
        .chk_hit1  (chk_hit1),
        .chk_hit2  (chk_hit2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           mq[$];
    wr_t           expq[$];
    int            total = 0;
    int            bad = 0;
    bit            frc;
    int            byp;
    bit            lw_v;
    logic [AW-1:0] lw_a;
    int            stall_m;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic bit hit(input logic [AW-1:0] c);
        if (c == '0) return 1'b0;
        foreach (mq[i]) if (mq[i].a == c) return 1'b1;
        return lw_v && (lw_a == c);
    endfunction

    // Scoreboard monitor: every commit must match the oldest expected one.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && rf_we) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got wa=%0d wd=%0h expected none",
                         rf_wa, rf_wd);
            end else begin
                e = expq.pop_front();
                chk("commit_addr", 64'(rf_wa), 64'(e.a));
                chk("commit_data", 64'(rf_wd), 64'(e.d));
            end
        end
    end

    task automatic cyc(input logic av, input logic [AW-1:0] aa,
                       input logic [DW-1:0] ad, input logic bv,
                       input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                       input logic [AW-1:0] c1, input logic [AW-1:0] c2);
        bit  ea, eb, g;
        wr_t w;
        @(negedge clk);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        chk_addr1 = c1; chk_addr2 = c2;
        #1;
        ea = !frc;
        eb = mq.size() < BD;
        chk("a_ready", 64'(a_ready), 64'(ea));
        chk("b_ready", 64'(b_ready), 64'(eb));
        chk("chk_hit1", 64'(chk_hit1), 64'(hit(c1)));
        chk("chk_hit2", 64'(chk_hit2), 64'(hit(c2)));
        chk("rf_we", 64'(rf_we), 64'(lw_v));
        if (av && !ea) stall_m++;
        g = 1'b0;
        w.a = '0;
        w.d = '0;
        if (mq.size() > 0 && (frc || !av)) begin
            w = mq.pop_front();
            g = 1'b1;
            byp = 0;
            frc = 1'b0;
        end else begin
            if (av && !frc && aa != '0) begin
                w.a = aa;
                w.d = ad;
                g = 1'b1;
            end
            if (mq.size() == 0) byp = 0;
            else begin
                byp++;
                if (byp >= MW) frc = 1'b1;
            end
        end
        if (bv && eb && ba != '0) mq.push_back('{ba, bd});
        if (g) expq.push_back(w);
        lw_v = g;
        lw_a = w.a;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Called #1 after a negedge: anything registered this cycle is lost.
    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk_addr1 = 5'd5;
        chk_addr2 = 5'd7;
        #1;
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_rf_wa", 64'(rf_wa), 64'd0);
        chk("rst_rf_wd", 64'(rf_wd), 64'd0);
        chk("rst_hit1", 64'(chk_hit1), 64'd0);
        chk("rst_hit2", 64'(chk_hit2), 64'd0);
        chk("rst_b_ready", 64'(b_ready), 64'd1);
        mq.delete();
        expq.delete();
        frc = 1'b0;
        byp = 0;
        lw_v = 1'b0;
        lw_a = '0;
        stall_m = 0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        a_valid = 0; a_addr = 0; a_data = 0;
        b_valid = 0; b_addr = 0; b_data = 0;
        chk_addr1 = 0; chk_addr2 = 0;
        do_reset();

        // A write to x5 with B idle
        cyc(1, 5, 32'h1234, 0, 0, 0, 5, 0);
        cyc(0, 0, 0, 0, 0, 0, 5, 0);
        chk("x5_wa", 64'(rf_wa), 64'd5);
        chk("x5_wd", 64'(rf_wd), 64'h1234);

        // x0 writes on both ports are swallowed
        cyc(1, 0, 32'hFFFF, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 32'h55, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("x0_rf_we", 64'(rf_we), 64'd0);
        idle(2);

        // B entry bypassed MAX_WAIT times, then forced
        cyc(1, 3, 32'h30, 1, 7, 32'hAA, 7, 0);
        for (int i = 0; i < 7; i++)
            cyc(1, AW'(i + 1), 32'h100 + i, 0, 0, 0, 7, 3);
        idle(3);

        // Fill past depth under constant A pressure; pointers wrap
        for (int i = 0; i < 40; i++)
            cyc(1, AW'(20 + i % 8), 32'h200 + i,
                1, AW'(8 + i % 8), 32'hB00 + i, AW'(8 + i % 8), 0);
        for (int k = 0; k < 64 && mq.size() > 0; k++) idle(1);
        idle(2);

        // Reset with three queued entries
        for (int i = 0; i < 3; i++)
            cyc(1, 2, 32'h300 + i, 1, AW'(9 + i), 32'hC00 + i, 9, 10);
        do_reset();
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 0, AW'(9 + i % 3), 0);

`ifdef RF_ARB_STATS_EN
        cyc(1, 1, 32'h1, 1, 12, 32'hD0, 0, 0);
        cyc(1, 1, 32'h2, 1, 13, 32'hD1, 0, 0);
        for (int i = 0; i < 12; i++) cyc(1, 1, 32'h3 + i, 0, 0, 0, 0, 0);
        chk("stall_cnt_two", 64'(stall_cnt), 64'd2);
        idle(4);
`endif

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            cyc(($urandom % 4) != 0, AW'($urandom_range(0, 7)), $urandom,
                $urandom % 2, AW'($urandom_range(0, 7)), $urandom,
                AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end
        for (int k = 0; k < 64 && mq.size() > 0; k++) idle(1);
        idle(2);
        chk("scoreboard_drained", 64'(expq.size()), 64'd0);
`ifdef RF_ARB_STATS_EN
        chk("stall_cnt_model", 64'(stall_cnt), 64'(stall_m));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
